// File: rtl/address_generator_mc.sv
// Multi-cycle bit-sliced address generator: rs1/pc + immediate, one SLICE per cycle,
// with a natural-alignment flag for loads, stores, jumps and branches.
module address_generator_mc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned C_EXT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] immediate,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] address,
  output logic            misaligned
);

  localparam int unsigned N  = XLEN / SLICE;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t            r_state, r_state_n;
  logic [XLEN-1:0]   r_a, r_b, r_sum, r_address;
  logic [6:0]        r_op;
  logic [1:0]        r_f3;
  logic [IW-1:0]     r_idx;
  logic              r_carry, r_mis;

  logic              w_accept, w_last, w_mis;
  logic [XLEN-1:0]   w_opa, w_opb, w_res;
  logic [SLICE:0]    w_slice_sum;
  logic              w_unused_f3;

  assign w_unused_f3 = funct3[2];

  assign in_ready   = ~reset & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept   = in_valid & in_ready;
  assign w_last     = (r_idx == IW'(N - 1));
  assign out_valid  = (r_state == S_DONE);
  assign address    = r_address;
  assign misaligned = r_mis;

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    case (opcode)
      OP_STORE, OP_LOAD, OP_JALR: begin w_opa = rs1; w_opb = immediate; end
      OP_JAL, OP_AUIPC, OP_BRANCH: begin w_opa = pc; w_opb = immediate; end
      default: ;
    endcase
  end

  // Current slice sum merged into the partial result; on the last slice this is the final address.
  always_comb begin
    w_slice_sum = {1'b0, r_a[r_idx*SLICE +: SLICE]} + {1'b0, r_b[r_idx*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, r_carry};
    w_res = r_sum;
    w_res[r_idx*SLICE +: SLICE] = w_slice_sum[SLICE-1:0];
    if (r_op == OP_JALR) w_res[0] = 1'b0;
  end

  always_comb begin
    w_mis = 1'b0;
    case (r_op)
      OP_LOAD, OP_STORE: begin
        case (r_f3)
          2'b00: w_mis = 1'b0;
          2'b01: w_mis = w_res[0];
          2'b10: w_mis = w_res[1] | w_res[0];
          2'b11: w_mis = |w_res[2:0];
          default: w_mis = 1'b0;
        endcase
      end
      OP_JAL, OP_JALR, OP_BRANCH: w_mis = (C_EXT == 0) ? w_res[1] : 1'b0;
      default: w_mis = 1'b0;
    endcase
  end

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      S_IDLE: if (in_valid) r_state_n = S_ADD;
      S_ADD:  if (w_last) r_state_n = S_DONE;
      S_DONE: if (out_ready) r_state_n = in_valid ? S_ADD : S_IDLE;
      default: r_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= r_state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_op      <= '0;
      r_f3      <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_address <= '0;
      r_mis     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= w_opa;
      r_b     <= w_opb;
      r_op    <= opcode;
      r_f3    <= funct3[1:0];
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_ADD) begin
      r_sum   <= w_res;
      r_carry <= w_slice_sum[SLICE];
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_address <= w_res;
        r_mis     <= w_mis;
      end
    end
  end

endmodule

// File: tb/tb_address_generator_mc.sv
// Directed bench: four instances (SLICE 8/32/4 and C_EXT=1) share stimulus;
// each result is checked for value, alignment flag and latency.
module tb_address_generator_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, pc = '0, immediate = '0;

  logic [3:0]  ir, ov, mis;
  logic [31:0] ad [4];

  int total = 0;
  int bad   = 0;
  int exp_lat [4] = '{4, 1, 8, 4};

  always #5 clk = ~clk;

  address_generator_mc #(.XLEN(32), .SLICE(8), .C_EXT(0)) u_s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .opcode(opcode),
    .funct3(funct3), .rs1(rs1), .pc(pc), .immediate(immediate), .out_valid(ov[0]),
    .out_ready(out_ready), .address(ad[0]), .misaligned(mis[0]));

  address_generator_mc #(.XLEN(32), .SLICE(32), .C_EXT(0)) u_s32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .opcode(opcode),
    .funct3(funct3), .rs1(rs1), .pc(pc), .immediate(immediate), .out_valid(ov[1]),
    .out_ready(out_ready), .address(ad[1]), .misaligned(mis[1]));

  address_generator_mc #(.XLEN(32), .SLICE(4), .C_EXT(0)) u_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .opcode(opcode),
    .funct3(funct3), .rs1(rs1), .pc(pc), .immediate(immediate), .out_valid(ov[2]),
    .out_ready(out_ready), .address(ad[2]), .misaligned(mis[2]));

  address_generator_mc #(.XLEN(32), .SLICE(8), .C_EXT(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .opcode(opcode),
    .funct3(funct3), .rs1(rs1), .pc(pc), .immediate(immediate), .out_valid(ov[3]),
    .out_ready(out_ready), .address(ad[3]), .misaligned(mis[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issues a request (draining any held result on the same edge), then holds
  // out_ready low for 10 cycles so every instance sits in DONE under back-pressure.
  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] a_rs1, input logic [31:0] a_pc, input logic [31:0] a_imm,
                     input logic [31:0] exp_addr, input logic exp_mis, input logic exp_mis_c);
    int lat [4];
    @(negedge clk);
    opcode = op; funct3 = f3; rs1 = a_rs1; pc = a_pc; immediate = a_imm;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_rdy_accept"}, {28'd0, ir}, 32'hF);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    rs1 = $urandom; pc = $urandom; immediate = $urandom; opcode = 7'($urandom); funct3 = 3'($urandom);
    check({tag, "_rdy_add"}, {31'd0, ir[0]}, 32'd0);
    for (int k = 0; k < 4; k++) lat[k] = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (ov[k] && lat[k] == 0) lat[k] = c;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_lat%0d", tag, k), 32'(lat[k]), 32'(exp_lat[k]));
      check($sformatf("%s_addr%0d", tag, k), ad[k], exp_addr);
    end
    check({tag, "_mis"}, {29'd0, mis[2:0]}, {29'd0, {3{exp_mis}}});
    check({tag, "_mis_c"}, {31'd0, mis[3]}, {31'd0, exp_mis_c});
    check({tag, "_hold"}, {24'd0, ov, ir}, {24'd0, 4'hF, 4'h0});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {ad[0] | ad[1] | ad[2] | ad[3]}, 32'd0);
    check("rst_flags", {20'd0, ov, mis, ir}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_rst_ready", {28'd0, ir}, 32'hF);

    run("load",    7'b0000011, 3'b010, 32'h0000_1000, 32'hDEAD_0000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0);
    run("store_c", 7'b0100011, 3'b001, 32'h0000_00FF, 32'h1234_5678, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    run("store_m", 7'b0100011, 3'b001, 32'h0000_00FF, 32'h1234_5678, 32'h0000_0000, 32'h0000_00FF, 1'b1, 1'b1);
    run("jalr",    7'b1100111, 3'b000, 32'h8000_0003, 32'h0000_0040, 32'h0000_0000, 32'h8000_0002, 1'b1, 1'b0);
    run("jal",     7'b1101111, 3'b000, 32'h5555_5555, 32'h0000_0100, 32'h0000_0002, 32'h0000_0102, 1'b1, 1'b0);
    run("auipc",   7'b0010111, 3'b000, 32'h0000_0001, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, 1'b0, 1'b0);
    run("unsup",   7'b0110011, 3'b011, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000, 1'b0, 1'b0);
    run("branch",  7'b1100011, 3'b001, 32'h0000_0007, 32'h0000_1000, 32'hFFFF_FFFE, 32'h0000_0FFE, 1'b1, 1'b0);
    run("ld_d_ok", 7'b0000011, 3'b011, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001, 32'h0000_0008, 1'b0, 1'b0);
    run("ld_d_mis",7'b0000011, 3'b011, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b1);
    run("ld_bu",   7'b0000011, 3'b100, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 1'b0, 1'b0);

    // Abort mid-ADD: reset in the second add cycle of the SLICE=8 instance.
    @(negedge clk);
    opcode = 7'b0000011; funct3 = 3'b000; rs1 = 32'h0000_1234; immediate = 32'h0000_0011;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_out", {ad[0] | ad[1] | ad[2] | ad[3]}, 32'd0);
    check("abort_flags", {20'd0, ov, mis, ir}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic [3:0] seen;
      seen = '0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1 seen = seen | ov;
      end
      check("abort_no_valid", {28'd0, seen}, 32'd0);
    end

    run("after_rst", 7'b0100011, 3'b010, 32'h0000_0FF0, 32'h0, 32'h0000_0012, 32'h0000_1002, 1'b1, 1'b1);

    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("drain", {28'd0, ov}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/address_generator_mc.md
# address_generator_mc

Multi-cycle, parametrised address generation unit for the phoeniX execute path. It accepts one address request per handshake and selects `rs1 + immediate` or `pc + immediate` from the RISC-V opcode. The sum is computed over a configurable number of bit-slices, one slice per cycle, so area can be traded against latency. Each result carries a natural-alignment flag for loads, stores, jumps and branches.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be a multiple of `SLICE`.
- `SLICE`, 8: adder bits processed per cycle; `N = XLEN/SLICE` add cycles.
- `C_EXT`, 0: 1 means control-flow targets need 2-byte alignment; 0 means 4-byte alignment.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `opcode`  in  7  RV opcode: STORE 0100011, LOAD 0000011, JALR 1100111, JAL 1101111, AUIPC 0010111, BRANCH 1100011.
- `funct3`  in  3  access size for LOAD/STORE; ignored otherwise.
- `rs1`, `pc`, `immediate`  in  XLEN  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `address`  out  XLEN  computed address, registered.
- `misaligned`  out  1  alignment violation, registered.

## Operation
- States are IDLE, ADD and DONE.
- IDLE:
  - `in_ready` is 1.
  - When `in_valid`, capture operand A, operand B, `opcode` and `funct3[1:0]`, clear the slice index and carry, then go to ADD.
  - A = `rs1` for STORE, LOAD and JALR. A = `pc` for JAL, AUIPC and BRANCH. B = `immediate` in both cases.
  - For any other opcode, A = B = 0. The request still runs full latency and produces `address` = 0 and `misaligned` = 0.
- ADD:
  - Each cycle, add slice `i` of A, slice `i` of B and the carry register.
  - Write the sum into slice `i` of the result register, update the carry and increment `i`.
  - After slice N-1, go to DONE. The final carry-out is discarded, so the result is modulo 2^XLEN.
- JALR: bit 0 of the result is forced to 0 before it is presented.
- DONE:
  - `out_valid` is 1. `address` and `misaligned` are held stable until `out_ready`.
  - On `out_ready`: if `in_valid`, capture the new request and go to ADD (back-to-back); otherwise go to IDLE.
- `misaligned` is computed from the final address `a`:
  - LOAD/STORE: `funct3[1:0]` 00 gives 0; 01 gives `a[0]`; 10 gives `a[1]|a[0]`; 11 gives `|a[2:0]`.
  - JAL/JALR/BRANCH: `a[1]` when `C_EXT`=0, otherwise 0 (JALR bit 0 is already cleared). A BRANCH is flagged regardless of whether it is taken; the consumer qualifies it.
  - AUIPC and unsupported opcodes: 0.
- Input ports are ignored outside acceptance cycles. Changing operands mid-operation has no effect.

## Timing
- Reset values while `reset` is high:
  - State IDLE.
  - `in_ready` 0.
  - `out_valid` 0, `address` 0, `misaligned` 0.
  - Slice index and carry 0.
- After reset is released, `in_ready` is 1 from the first cycle.
- Reset asserted mid-ADD or in DONE aborts immediately and discards the result.
- `in_ready` is 1 in IDLE, and in DONE when `out_ready` is 1. It is 0 in ADD.
- Latency: a request accepted at clock edge k gives `out_valid` = 1 after edge k+N. For default parameters, N = 4.
  - `SLICE` = `XLEN` gives 1-cycle latency.
- Throughput with back-to-back requests and `out_ready` tied high: one result per N+1 cycles.
- `out_valid` drops on the edge after the `out_valid & out_ready` handshake unless a new result completes on that edge. This cannot happen for N ≥ 1.
- `address` and `misaligned` change only on the transition into DONE.

## Test plan
- LOAD, `rs1`=0x0000_1000, `immediate`=0xFFFF_FFFC, `funct3`=010, defaults -> 4 edges after acceptance: `address`=0x0000_0FFC, `misaligned`=0.
- STORE, `rs1`=0x0000_00FF, `immediate`=0x0000_0001, `funct3`=001 -> `address`=0x0000_0100 (carry ripples across slices 0→1), `misaligned`=0. Repeat with `immediate`=0 -> `address`=0x0000_00FF, `misaligned`=1.
- JALR, `rs1`=0x8000_0003, `immediate`=0; and JAL, `pc`=0x100, `immediate`=0x2 -> JALR gives `address`=0x8000_0002, `misaligned`=1 (`C_EXT`=0). JAL gives 0x102, `misaligned`=1; with `C_EXT`=1, `misaligned`=0.
- AUIPC, `pc`=0xFFFF_FFF0, `immediate`=0x0000_0020 -> `address`=0x0000_0010 (wrap-around), `misaligned`=0. Opcode 0110011 -> `address`=0, `misaligned`=0, same latency.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE -> `address` stable, `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 -> new request accepted on the same edge, next `out_valid` exactly 4 edges later.
- Assert `reset` during the 2nd ADD cycle -> outputs immediately go to 0, `out_valid` never rises for that request. The next request after reset completes correctly. Repeat all scenarios with `SLICE`=32 and `SLICE`=4 for latencies of 1 and 8.
